jif_core: RTL and testbench



---
 rtl/jif_pkg.sv | 61 ++++++
 rtl/jif_alu.sv | 60 ++++++
 rtl/jif_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_jif_core.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jif_pkg.sv
`default_nettype none
//==============================================================================
// jif_pkg: opcodes, FSM states and instruction field positions for jif_core.
// Optional MUL is enabled by defining JIF_CORE_MUL_EN.  Revision: 1.0
//==============================================================================
package jif_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_LDI   = 4'd6,
        OP_LD    = 4'd7,
        OP_ST    = 4'd8,
        OP_JMP   = 4'd9,
        OP_BF    = 4'd10,
        OP_CMP   = 4'd11,
        OP_MUL   = 4'd12,
        OP_UND13 = 4'd13,
        OP_UND14 = 4'd14,
        OP_HALT  = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam int F_OP_MSB  = 31;
    localparam int F_OP_LSB  = 28;
    localparam int F_RD_MSB  = 27;
    localparam int F_RD_LSB  = 24;
    localparam int F_RA_MSB  = 23;
    localparam int F_RA_LSB  = 20;
    localparam int F_RB_MSB  = 19;
    localparam int F_RB_LSB  = 16;
    localparam int F_IMM_MSB = 15;
    localparam int F_IMM_LSB = 0;

    // Undefined opcodes retire as NOP and raise the illegal pulse.
    function automatic logic op_illegal(input opcode_t op);
        case (op)
            OP_UND13, OP_UND14: return 1'b1;
`ifdef JIF_CORE_MUL_EN
            OP_MUL:             return 1'b0;
`else
            OP_MUL:             return 1'b1;
`endif
            default:            return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/jif_alu.sv
`default_nettype none
//==============================================================================
// jif_alu: combinational ALU for jif_core; MUL present only with JIF_CORE_MUL_EN.
// Revision: 1.0
//==============================================================================
module jif_alu
    import jif_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  opcode_t           op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   result,
    output logic              flag_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    // The extra top bit carries out of ADD and is the borrow of SUB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef JIF_CORE_MUL_EN
    logic [2*XLEN-1:0] prod;
    assign prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
`endif

    always_comb begin
        result   = '0;
        flag_out = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum[XLEN-1:0];
                flag_out = sum[XLEN];
            end
            OP_SUB: begin
                result   = diff[XLEN-1:0];
                flag_out = diff[XLEN];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_CMP: flag_out = (a == b);
`ifdef JIF_CORE_MUL_EN
            OP_MUL: begin
                result   = prod[XLEN-1:0];
                flag_out = |prod[2*XLEN-1:XLEN];
            end
`endif
            default: begin
                result   = '0;
                flag_out = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/jif_core.sv
`default_nettype none
//==============================================================================
// jif_core: parametrised multicycle CPU with req/ready memory port.
// Define JIF_CORE_MUL_EN to add the MUL opcode.  Revision: 1.0
//==============================================================================
module jif_core
    import jif_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter int             NREGS    = 8,
    parameter int             AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0
)(
    input  logic              clock,
    input  logic              reset,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              halted,
    output logic              illegal,
    output logic [AW-1:0]     pc_out
);

    localparam int IW = $clog2(NREGS);

    state_t             state;
    state_t             next_state;

    logic [31:0]        instr;
    logic [XLEN-1:0]    regs [NREGS];
    logic [NREGS-1:0]   flags;
    logic [XLEN-1:0]    opa;
    logic [XLEN-1:0]    opb;
    logic               fa;
    logic [XLEN-1:0]    res;
    logic               fres;
    logic [AW-1:0]      pc;
    logic [AW-1:0]      npc;

    opcode_t            op;
    logic [3:0]         rd;
    logic [3:0]         ra;
    logic [3:0]         rb;
    logic [XLEN-1:0]    sext;
    logic [XLEN-1:0]    alu_res;
    logic               alu_flag;
    logic [AW-1:0]      pc_inc;
    logic [AW-1:0]      ea_w;
    logic [AW-1:0]      npc_w;
    logic               wr_reg;
    logic               wr_flag;

    logic               req_d;
    logic               we_d;
    logic [AW-1:0]      addr_d;
    logic [XLEN-1:0]    wdata_d;
    logic               halted_d;
    logic               illegal_d;

    assign op     = opcode_t'(instr[F_OP_MSB:F_OP_LSB]);
    assign rd     = instr[F_RD_MSB:F_RD_LSB];
    assign ra     = instr[F_RA_MSB:F_RA_LSB];
    assign rb     = instr[F_RB_MSB:F_RB_LSB];
    assign sext   = {{(XLEN-16){instr[F_IMM_MSB]}}, instr[F_IMM_MSB:F_IMM_LSB]};
    assign pc_out = pc;

    // Indices beyond the implemented register count read as zero and drop writes.
    function automatic logic idx_ok(input logic [3:0] i);
        return int'(i) < NREGS;
    endfunction

    jif_alu #(
        .XLEN     (XLEN)
    ) u_alu (
        .op       (op),
        .a        (opa),
        .b        (opb),
        .result   (alu_res),
        .flag_out (alu_flag)
    );

    always_comb begin
        pc_inc = pc + AW'(1);
        ea_w   = opa[AW-1:0] + sext[AW-1:0];
        case (op)
            OP_JMP:  npc_w = ea_w;
            OP_BF:   npc_w = fa ? (pc_inc + sext[AW-1:0]) : pc_inc;
            default: npc_w = pc_inc;
        endcase
    end

    always_comb begin
        wr_reg  = 1'b0;
        wr_flag = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                wr_reg  = 1'b1;
                wr_flag = 1'b1;
            end
            OP_LDI, OP_LD: wr_reg  = 1'b1;
            OP_CMP:        wr_flag = 1'b1;
            OP_MUL: begin
                wr_reg  = !op_illegal(op);
                wr_flag = !op_illegal(op);
            end
            default: begin
                wr_reg  = 1'b0;
                wr_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are registered from their next values so each state drives the bus
    // from its very first cycle.
    always_comb begin
        next_state = state;
        req_d      = mem_req;
        we_d       = mem_we;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        halted_d   = halted;
        illegal_d  = 1'b0;
        case (state)
            S_FETCH: begin
                req_d  = 1'b1;
                we_d   = 1'b0;
                addr_d = pc;
                if (mem_req && mem_ready) begin
                    next_state = S_DECODE;
                    req_d      = 1'b0;
                end
            end
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_LD, OP_ST: begin
                        next_state = S_MEM;
                        req_d      = 1'b1;
                        we_d       = (op == OP_ST);
                        addr_d     = ea_w;
                        wdata_d    = opb;
                    end
                    OP_HALT: begin
                        next_state = S_HALT;
                        halted_d   = 1'b1;
                    end
                    default: begin
                        next_state = S_WB;
                        illegal_d  = op_illegal(op);
                    end
                endcase
            end
            S_MEM: begin
                if (mem_req && mem_ready) begin
                    next_state = S_WB;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                end
            end
            S_WB: begin
                next_state = S_FETCH;
                req_d      = 1'b1;
                we_d       = 1'b0;
                addr_d     = npc;
            end
            S_HALT: begin
                req_d    = 1'b0;
                halted_d = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            halted    <= halted_d;
            illegal   <= illegal_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            npc   <= RESET_PC;
            instr <= '0;
            opa   <= '0;
            opb   <= '0;
            fa    <= 1'b0;
            res   <= '0;
            fres  <= 1'b0;
            flags <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_req && mem_ready) begin
                        instr <= mem_rdata[31:0];
                    end
                end
                S_DECODE: begin
                    opa <= idx_ok(ra) ? regs[ra[IW-1:0]] : '0;
                    opb <= idx_ok(rb) ? regs[rb[IW-1:0]] : '0;
                    fa  <= idx_ok(ra) ? flags[ra[IW-1:0]] : 1'b0;
                end
                S_EXEC: begin
                    res  <= (op == OP_LDI) ? sext : alu_res;
                    fres <= alu_flag;
                    npc  <= npc_w;
                end
                S_MEM: begin
                    if (mem_req && mem_ready && !mem_we) begin
                        res <= mem_rdata;
                    end
                end
                S_WB: begin
                    pc <= npc;
                    if (wr_reg && idx_ok(rd)) begin
                        regs[rd[IW-1:0]] <= res;
                    end
                    if (wr_flag && idx_ok(rd)) begin
                        flags[rd[IW-1:0]] <= fres;
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jif_core.sv
`default_nettype none
// tb_jif_core: directed program run on jif_core against a wait-state memory model.
module tb_jif_core;

    localparam int            XLEN   = 32;
    localparam int            NREGS  = 8;
    localparam int            AW     = 16;
    localparam logic [AW-1:0] RST_PC = 16'h0100;

    logic              clock     = 1'b0;
    logic              reset     = 1'b1;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ready = 1'b0;
    logic              halted;
    logic              illegal;
    logic [AW-1:0]     pc_out;

    jif_core #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .AW        (AW),
        .RESET_PC  (RST_PC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .halted    (halted),
        .illegal   (illegal),
        .pc_out    (pc_out)
    );

    always #5 clock = ~clock;

    logic [31:0]   mem [0:65535];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            wcnt = 0;
    int            fetch_wait = 0;
    int            st_wait = 3;
    int            nfetch = 0;
    logic [AW-1:0] f_addr [32];
    int            f_cyc [32];
    int            illegal_cnt = 0;
    int            st_req_cnt = 0;
    int            st_bad = 0;
    int            halt_req_cnt = 0;

    logic [AW-1:0] exp_addr [17] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104,
                                     16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0020,
                                     16'h001F, 16'h0020, 16'h0021, 16'h0022, 16'hFFFF,
                                     16'h0000, 16'h0040};
    int            exp_lat [16] = '{4, 4, 4, 4, 4, 8, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: ready is decided on the falling edge, the handshake lands on
    // the next rising edge. Stores take st_wait waits, fetches fetch_wait, loads none.
    always @(negedge clock) begin
        int need;
        cyc++;
        need = mem_we ? st_wait : ((mem_addr == pc_out) ? fetch_wait : 0);
        if (mem_req) begin
            if (wcnt >= need) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end
        mem_rdata = mem[mem_addr];
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
            end else if (mem_addr == pc_out && nfetch < 32) begin
                f_addr[nfetch] = mem_addr;
                f_cyc[nfetch]  = cyc;
                nfetch++;
            end
        end
        if (mem_req && mem_we) begin
            st_req_cnt++;
            if (mem_addr != 16'h0010 || mem_wdata != 32'd5) st_bad++;
        end
        if (illegal) illegal_cnt++;
        if (halted && mem_req) halt_req_cnt++;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[16'h0100] = 32'h6100_0005;  // LDI r1,5
        mem[16'h0101] = 32'h6200_FFFD;  // LDI r2,-3
        mem[16'h0102] = 32'h1312_0000;  // ADD r3,r1,r2
        mem[16'h0103] = 32'h2421_0000;  // SUB r4,r2,r1
        mem[16'h0104] = 32'h2512_0000;  // SUB r5,r1,r2
        mem[16'h0105] = 32'h8001_0010;  // ST  r1,[r0+0x10]
        mem[16'h0106] = 32'h7600_0010;  // LD  r6,[r0+0x10]
        mem[16'h0107] = 32'hB711_0000;  // CMP r7,r1,r1
        mem[16'h0108] = 32'h9000_0020;  // JMP r0+0x20
        mem[16'h001F] = 32'hB712_0000;  // CMP r7,r1,r2
        mem[16'h0020] = 32'hA070_FFFE;  // BF  r7,-2
        mem[16'h0021] = 32'hD300_0000;  // opcode 13
        mem[16'h0022] = 32'h9000_FFFF;  // JMP r0-1 -> 0xFFFF
        mem[16'hFFFF] = 32'h0000_0000;  // NOP, wraps to 0
        mem[16'h0000] = 32'h9040_0048;  // JMP r4+0x48 -> 0x0040 (mod 2^16)
        mem[16'h0040] = 32'hF000_0000;  // HALT

        repeat (3) @(negedge clock);
        check("rst_req",   mem_req,   1'b0);
        check("rst_we",    mem_we,    1'b0);
        check("rst_halt",  halted,    1'b0);
        check("rst_ill",   illegal,   1'b0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_addr",  mem_addr,  RST_PC);
        check("rst_pc",    pc_out,    RST_PC);
        reset = 1'b0;
        @(negedge clock);
        check("req_rise", mem_req, 1'b1);

        begin
            int n = 0;
            while (!halted && n < 3000) begin
                @(negedge clock);
                n++;
            end
        end
        check("halt_reached", halted, 1'b1);
        repeat (10) @(negedge clock);
        check("halt_hold",     halted,       1'b1);
        check("halt_req_now",  mem_req,      1'b0);
        check("halt_req_cnt",  halt_req_cnt, 0);

        check("fetch_count", nfetch, 17);
        for (int i = 0; i < 17; i++) begin
            if (i < nfetch) check($sformatf("fetch_addr%0d", i), f_addr[i], exp_addr[i]);
        end
        for (int i = 0; i < 16; i++) begin
            if (i + 1 < nfetch) check($sformatf("latency%0d", i), f_cyc[i+1] - f_cyc[i], exp_lat[i]);
        end

        check("r1", dut.regs[1], 32'h0000_0005);
        check("r2", dut.regs[2], 32'hFFFF_FFFD);
        check("r3", dut.regs[3], 32'h0000_0002);
        check("r4", dut.regs[4], 32'hFFFF_FFF8);
        check("r5", dut.regs[5], 32'h0000_0008);
        check("r6", dut.regs[6], 32'h0000_0005);
        check("r7", dut.regs[7], 32'h0000_0000);
        check("flags", dut.flags, 8'h28);
        check("mem10", mem[16'h0010], 32'h0000_0005);
        check("illegal_cycles", illegal_cnt, 1);
        check("st_req_cycles",  st_req_cnt,  4);
        check("st_bus_stable",  st_bad,      0);

        fetch_wait = 1000;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("wait_req",  mem_req,  1'b1);
        check("wait_addr", mem_addr, RST_PC);
        check("wait_halt", halted,   1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_req", mem_req,      1'b0);
        check("async_pc",  pc_out,       RST_PC);
        check("async_r1",  dut.regs[1],  32'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
